// File: rtl/irq_pulse_generator.sv
// -----------------------------------------------------------------------------
// irq_pulse_generator
//
// Avalon-MM slave that raises programmable periodic interrupts. A single reload
// timer produces events; each event is handed round-robin to the next enabled
// IRQ channel, whose pending bit stays set until software write-1-clears it.
// Events that land on an already-pending channel are counted as missed.
//
// Register map (word addresses, unused bits read 0):
//   0 CONTROL      bit0 run, bits[8+NUM_IRQ-1:8] channel enable mask
//   1 PERIOD       reload value P (event interval is P+1 cycles)
//   2 STATUS       pending[NUM_IRQ-1:0] (W1C), rr_ptr in bits[19:16] (RO)
//   3 IRQ_COUNT    interrupts raised, any write clears
//   4 MISSED_COUNT events that hit a pending channel, any write clears
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   address        word address
//   read / write   bus strobes (never stalled)
//   writedata      write data
//   readdata       registered read data
//   readdatavalid  one-cycle pulse, one cycle after an accepted read
//   irq            level interrupt per channel (mirrors pending)
// -----------------------------------------------------------------------------
module irq_pulse_generator #(
  parameter int NUM_IRQ      = 4,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               readdatavalid,
  output logic [NUM_IRQ-1:0] irq
);

  localparam int PTR_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {
    ADDR_CONTROL      = 3'd0,
    ADDR_PERIOD       = 3'd1,
    ADDR_STATUS       = 3'd2,
    ADDR_IRQ_COUNT    = 3'd3,
    ADDR_MISSED_COUNT = 3'd4
  } reg_addr_e;

  // Architectural state
  logic                    run;
  logic                    run_d;
  logic [NUM_IRQ-1:0]      mask;
  logic [PERIOD_WIDTH-1:0] period;
  logic [PERIOD_WIDTH-1:0] counter;
  logic [NUM_IRQ-1:0]      pending;
  logic [PTR_W-1:0]        rr_ptr;
  logic [31:0]             irq_count;
  logic [31:0]             missed_count;

  // Write decodes
  logic wr_control;
  logic wr_period;
  logic wr_status;
  logic wr_irq_count;
  logic wr_missed_count;

  assign wr_control      = write && (address == ADDR_CONTROL);
  assign wr_period       = write && (address == ADDR_PERIOD);
  assign wr_status       = write && (address == ADDR_STATUS);
  assign wr_irq_count    = write && (address == ADDR_IRQ_COUNT);
  assign wr_missed_count = write && (address == ADDR_MISSED_COUNT);

  // Timer: the cycle in which run first reads 1 only loads P, so a stale
  // counter value of 0 can never fire a spurious event at start-up.
  logic timer_active;
  logic run_rise;
  logic evt;

  assign timer_active = run && run_d;
  assign run_rise     = run && !run_d;
  assign evt          = timer_active && (counter == '0);

  // Round-robin channel selection: first enabled channel at or after rr_ptr.
  logic [PTR_W-1:0] sel;
  logic             found;
  logic [PTR_W:0]   cand;
  logic [PTR_W:0]   ptr_inc;
  logic [PTR_W-1:0] next_ptr;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_IRQ)) cand = cand - (PTR_W+1)'(NUM_IRQ);
      if (!found && mask[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, sel} + (PTR_W+1)'(1);
    if (ptr_inc == (PTR_W+1)'(NUM_IRQ)) ptr_inc = '0;
    next_ptr = ptr_inc[PTR_W-1:0];
  end

  // Dispatch outcome. The event's set of pending[sel] overrides a W1C of the
  // same bit in the same cycle.
  logic               dispatch;
  logic               raise;
  logic               miss;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;

  assign dispatch = evt && found;
  assign raise    = dispatch && !pending[sel];
  assign miss     = dispatch &&  pending[sel];
  assign clr_vec  = wr_status ? writedata[NUM_IRQ-1:0] : '0;

  always_comb begin
    set_vec = '0;
    if (dispatch) set_vec[sel] = 1'b1;
  end

  // Read mux sees pre-write state, so a simultaneous read+write returns the
  // old value.
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CONTROL: begin
        rd_mux[0]            = run;
        rd_mux[8 +: NUM_IRQ] = mask;
      end
      ADDR_PERIOD:       rd_mux[PERIOD_WIDTH-1:0] = period;
      ADDR_STATUS: begin
        rd_mux[NUM_IRQ-1:0]  = pending;
        rd_mux[16 +: PTR_W]  = rr_ptr;
      end
      ADDR_IRQ_COUNT:    rd_mux = irq_count;
      ADDR_MISSED_COUNT: rd_mux = missed_count;
      default:           rd_mux = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: this block holds only plain registers (no memory arrays), so
      // every one of them is reset to 0, including the read-data register.
      run           <= 1'b0;
      run_d         <= 1'b0;
      mask          <= '0;
      period        <= '0;
      counter       <= '0;
      pending       <= '0;
      rr_ptr        <= '0;
      irq_count     <= '0;
      missed_count  <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      run_d <= run;

      if (wr_control) begin
        run  <= writedata[0];
        mask <= writedata[8 +: NUM_IRQ];
      end

      if (wr_period) period <= writedata[PERIOD_WIDTH-1:0];

      if (run_rise || evt)   counter <= period;
      else if (timer_active) counter <= counter - PERIOD_WIDTH'(1);

      if (dispatch) rr_ptr <= next_ptr;

      pending <= (pending & ~clr_vec) | set_vec;

      // A clear and an increment in the same cycle leave the count at 1.
      irq_count    <= (wr_irq_count    ? 32'd0 : irq_count)    + 32'(raise);
      missed_count <= (wr_missed_count ? 32'd0 : missed_count) + 32'(miss);

      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

  assign irq = pending;

endmodule

// File: tb/tb_irq_pulse_generator.sv
module tb_irq_pulse_generator;

  localparam int NUM_IRQ = 4;
  localparam int PW      = 32;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [2:0]         address = '0;
  logic               read = 1'b0;
  logic               write = 1'b0;
  logic [31:0]        writedata = '0;
  logic [31:0]        readdata;
  logic               readdatavalid;
  logic [NUM_IRQ-1:0] irq;

  always #5 clk = ~clk;

  irq_pulse_generator #(.NUM_IRQ(NUM_IRQ), .PERIOD_WIDTH(PW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .irq           (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: events are scheduled by absolute edge number
  // (run start -> first irq edge at +P+2, then every P+1 edges), dispatch is a
  // modulo scan of the enable mask.
  // ---------------------------------------------------------------------------
  logic               m_run    = 1'b0;
  logic [NUM_IRQ-1:0] m_mask   = '0;
  logic [31:0]        m_period = '0;
  logic [NUM_IRQ-1:0] m_pend   = '0;
  int                 m_rr     = 0;
  logic [31:0]        m_irqcnt = '0;
  logic [31:0]        m_missed = '0;
  longint             m_edge   = 0;
  longint             m_ev_edge = -1;
  logic [31:0]        exp_q[$];

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: begin v[0] = m_run; v[8 +: NUM_IRQ] = m_mask; end
      3'd1: v = m_period;
      3'd2: begin v[NUM_IRQ-1:0] = m_pend; v[19:16] = 4'(m_rr); end
      3'd3: v = m_irqcnt;
      3'd4: v = m_missed;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic               evt;
    logic               new_run;
    logic [NUM_IRQ-1:0] set_v;
    logic               inc_i;
    logic               inc_m;
    int                 c;
    m_edge++;
    if (!reset_n) begin
      m_run = 1'b0; m_mask = '0; m_period = '0; m_pend = '0; m_rr = 0;
      m_irqcnt = '0; m_missed = '0; m_ev_edge = -1;
    end else begin
      if (read) exp_q.push_back(model_read(address));
      evt   = m_run && (m_edge == m_ev_edge);
      set_v = '0; inc_i = 1'b0; inc_m = 1'b0; c = 0;
      if (evt && (m_mask != '0)) begin
        for (int k = 0; k < NUM_IRQ; k++) begin
          c = (m_rr + k) % NUM_IRQ;
          if (m_mask[c]) break;
        end
        m_rr = (c + 1) % NUM_IRQ;
        if (m_pend[c]) inc_m = 1'b1;
        else           inc_i = 1'b1;
        set_v[c] = 1'b1;
      end
      if (evt) m_ev_edge = m_edge + longint'(m_period) + 1;
      new_run = m_run;
      if (write && address == 3'd0) new_run = writedata[0];
      if (!m_run && new_run) m_ev_edge = m_edge + longint'(m_period) + 2;
      if (write) begin
        case (address)
          3'd0: begin m_run = writedata[0]; m_mask = writedata[8 +: NUM_IRQ]; end
          3'd1: m_period = writedata;
          3'd2: m_pend = m_pend & ~writedata[NUM_IRQ-1:0];
          3'd3: m_irqcnt = '0;
          3'd4: m_missed = '0;
          default: ;
        endcase
      end
      m_pend   = m_pend | set_v;
      m_irqcnt = m_irqcnt + 32'(inc_i);
      m_missed = m_missed + 32'(inc_m);
    end
  end

  // Monitor / scoreboard: sampled on the falling edge.
  always @(negedge clk) begin : monitor
    logic [31:0] exp_v;
    check("irq_level", 32'(irq), 32'(m_pend));
    check("readdatavalid", 32'(readdatavalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      if (readdatavalid) check("readdata", readdata, exp_v);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus helpers
  // ---------------------------------------------------------------------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    @(negedge clk);
    address = a; read = 1'b1; write = 1'b0;
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for any of 'bits' on irq; checks edges elapsed since 'start'.
  task automatic wait_irq(input logic [NUM_IRQ-1:0] bits, input int budget,
                          input longint start, input string name, input int exp_lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((irq & bits) != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 32'(irq & bits), 32'(bits));
    else       check(name, 32'(m_edge - start), 32'(exp_lat));
  endtask

  task automatic clear_all();
    bus_write(3'd0, 32'h0);
    bus_write(3'd2, 32'hF);
    bus_write(3'd3, 32'h0);
    bus_write(3'd4, 32'h0);
  endtask

  initial begin : stimulus
    longint start;
    int r;
    logic [2:0]  a;
    logic [31:0] d;

    // Reset, then every register reads 0.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) bus_read(3'(i));

    // P=9, all channels, clear each irq as soon as it appears.
    bus_write(3'd1, 32'd9);
    bus_write(3'd0, 32'h0000_0F01);
    start = m_edge;
    wait_irq(4'b0001, 40, start, "first_irq_latency_p9", 11);
    repeat (72) begin
      address = 3'd2; writedata = 32'(irq); write = (irq != '0);
      @(negedge clk);
    end
    write = 1'b0;
    bus_write(3'd0, 32'h0);
    bus_read(3'd3);
    bus_read(3'd4);
    bus_read(3'd2);

    // P=4, mask 0b0101, nobody clears: 2 raised then misses.
    clear_all();
    bus_write(3'd1, 32'd4);
    bus_write(3'd0, 32'h0000_0501);
    repeat (6) begin
      idle(3);
      bus_read(3'd2);
    end
    bus_read(3'd3);
    bus_read(3'd4);

    // W1C of bit0 in the exact cycle ch0 is re-raised.
    clear_all();
    bus_write(3'd1, 32'd4);
    bus_write(3'd0, 32'h0000_0101);
    start = m_edge;
    wait_irq(4'b0001, 20, start, "first_irq_latency_p4", 6);
    address = 3'd2; writedata = 32'h1; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    idle(3);
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    check("collision_irq0_held", 32'(irq[0]), 32'd1);
    bus_read(3'd3);

    // mask=0 with run: events are discarded.
    clear_all();
    bus_write(3'd0, 32'h0000_0001);
    idle(50);
    bus_read(3'd3);
    bus_read(3'd4);
    bus_write(3'd0, 32'h0);
    bus_write(3'd1, 32'd2);
    bus_write(3'd0, 32'h0000_0101);
    start = m_edge;
    wait_irq(4'b0001, 20, start, "first_irq_latency_p2", 4);

    // IRQ_COUNT wrap from 0xFFFFFFFF to 0.
    clear_all();
    @(negedge clk);
    force dut.irq_count = 32'hFFFF_FFFE;
    m_irqcnt = 32'hFFFF_FFFE;
    #1;
    release dut.irq_count;
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'h0000_0F01);
    @(negedge clk);
    address = 3'd3; read = 1'b1;
    repeat (8) @(negedge clk);
    read = 1'b0;
    bus_write(3'd0, 32'h0);
    bus_read(3'd3);
    bus_read(3'd4);

    // Random traffic, including simultaneous read+write.
    clear_all();
    bus_write(3'd1, 32'd1);
    bus_write(3'd0, 32'h0000_0F01);
    repeat (1500) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if ((a == 3'd3 || a == 3'd4) && $urandom_range(0, 7) != 0) a = 3'd2;
      if (a == 3'd1) d = d & 32'h7;
      if (a == 3'd0) d[0] = ($urandom_range(0, 9) != 0);
      address   = a;
      writedata = d;
      read      = (r < 40) || (r >= 95);
      write     = (r >= 40 && r < 80) || (r >= 95);
    end
    @(negedge clk);
    read = 1'b0; write = 1'b0;

    // Reset mid-burst with a read in flight.
    bus_write(3'd1, 32'd1);
    bus_write(3'd0, 32'h0000_0F01);
    idle(7);
    @(negedge clk);
    reset_n = 1'b0; read = 1'b1; address = 3'd3;
    @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_readdatavalid", 32'(readdatavalid), 32'd0);
    check("reset_readdata", readdata, 32'd0);
    read = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 8; i++) bus_read(3'(i));
    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
